map_client_sequencer: RTL and testbench
=======================================

Name: map_client_sequencer

Overview:
Requester-side front end for the team's key/value map block. Buffers tagged commands (insert, delete, lookup, nop) in a small FIFO and issues them one at a time on the map's op/key/value/valid interface. Samples the map's same-cycle lookup result and returns one tagged response per command on a valid/ready response port. Also keeps saturating hit, miss and full statistics.

Parameters:
KEY_WIDTH, 8, key width; must match the map.
VALUE_WIDTH, 16, value width; must match the map.
TAG_WIDTH, 4, opaque command tag returned with the response.
CMD_DEPTH, 4, command FIFO depth; power of 2, at least 2.
FULL_TIMEOUT, 8, cycles an INSERT waits for map_ready before failing; 0 means wait forever.
COUNT_WIDTH, 16, width of each statistics counter.

Ports:
clk  in  1  clock.
reset  in  1  asynchronous, active-low reset.
cmd_valid  in  1  command offered.
cmd_ready  out  1  FIFO can accept a command.
cmd_op  in  2  0 NOP, 1 INSERT, 2 DELETE, 3 LOOKUP.
cmd_key  in  KEY_WIDTH  command key.
cmd_value  in  VALUE_WIDTH  insert value.
cmd_tag  in  TAG_WIDTH  command tag.
map_op  out  2  op to map.
map_key  out  KEY_WIDTH  key to map.
map_value  out  VALUE_WIDTH  value to map.
map_valid  out  1  valid to map.
map_ready  in  1  map not full.
map_rsp_value  in  VALUE_WIDTH  map lookup value (combinational).
map_rsp_hit  in  1  map lookup hit (combinational, LOOKUP only).
rsp_valid  out  1  response valid.
rsp_ready  in  1  consumer accepts the response.
rsp_tag  out  TAG_WIDTH  tag of the completed command.
rsp_op  out  2  op of the completed command.
rsp_value  out  VALUE_WIDTH  lookup value; 0 otherwise.
rsp_status  out  2  0 OK, 1 MISS, 2 FULL.
hit_count, miss_count, full_count  out  COUNT_WIDTH each  saturating statistics counters.

Behaviour:
- Reset (reset low, asynchronous): FIFO empty, FSM in IDLE, wait counter 0, all counters 0.
- Reset output values: cmd_ready=1, map_valid=0, map_op=NOP, map_key=0, map_value=0, rsp_valid=0, all rsp_* fields 0.
- A reset asserted mid-command drops the command silently; no response is produced.
- FIFO:
  - cmd_ready = (count != CMD_DEPTH).
  - A push occurs on cmd_valid && cmd_ready.
  - Push and pop in the same cycle are allowed; count is unchanged.
  - When full, a push is refused even if a pop occurs in that cycle.
  - Pointers wrap modulo CMD_DEPTH.
- IDLE:
  - If the FIFO is non-empty, pop the head into the command register. Next state is ISSUE, or RESP if the op is NOP.
  - NOP never drives the map.
- ISSUE:
  - map_valid=1 and map_op/key/value come from the command register. In every other state map_valid=0 and map_op=NOP.
  - LOOKUP: exactly one cycle. Sample map_rsp_hit and map_rsp_value in this cycle.
    - Hit: status OK, value = map_rsp_value, hit_count++.
    - Miss: status MISS, value 0, miss_count++.
  - DELETE: exactly one cycle. Status OK, value 0. Hit/miss is not reported because the map gives no delete indication.
  - INSERT:
    - Completes in the first ISSUE cycle with map_ready=1; status OK.
    - Otherwise the wait counter increments each cycle.
    - If FULL_TIMEOUT != 0 and the counter reaches FULL_TIMEOUT-1 with map_ready still 0: status FULL, full_count++, leave ISSUE with no map write. map_valid is asserted for exactly FULL_TIMEOUT cycles.
    - The wait counter clears on leaving ISSUE.
  - Next state is always RESP.
- RESP:
  - rsp_valid=1; all rsp_* fields are registered and held stable until rsp_valid && rsp_ready.
  - On the handshake, go to IDLE.
- Latency with rsp_ready=1 and no map stall: a command pushed at cycle T has its response valid at T+3 (NOP at T+2).
- Throughput is one command per 3 cycles.
- Statistics counters saturate at all-ones.
- Responses are returned strictly in command order; only one command is in flight.

Test Plan:
- After reset, push INSERT key 0x12 value 0xBEEF tag 1 with map_ready=1 -> exactly one map_valid cycle with map_op=1, key 0x12, value 0xBEEF; response tag 1, status OK, rsp_value 0.
- LOOKUP key 0x12 tag 2 with map_rsp_hit=1, map_rsp_value=0xBEEF -> response status OK, value 0xBEEF, hit_count=1; repeat with hit=0 -> status MISS, value 0, miss_count=1.
- INSERT with map_ready held 0 and FULL_TIMEOUT=8 -> map_valid high exactly 8 cycles, response status FULL, full_count=1; raising map_ready on cycle 3 -> status OK after 3 issue cycles.
- Push 5 commands back-to-back with rsp_ready=0 and CMD_DEPTH=4 -> 1 command held in RESP, 4 in the FIFO, cmd_ready=0; release rsp_ready -> all 5 responses in order with tags preserved and held stable while stalled.
- NOP tag 7 -> map_valid never asserted; response tag 7, status OK, at T+2.
- Reset asserted while an INSERT waits in ISSUE -> map_valid=0 immediately, no response, FIFO empty, cmd_ready=1.

Source files
------------

// File: rtl/map_client_sequencer.sv
// Requester front end for the key/value map: queues tagged commands, issues them
// one at a time, and returns one tagged response per command with hit/miss/full stats.
module map_client_sequencer #(
    parameter int KEY_WIDTH    = 8,
    parameter int VALUE_WIDTH  = 16,
    parameter int TAG_WIDTH    = 4,
    parameter int CMD_DEPTH    = 4,
    parameter int FULL_TIMEOUT = 8,
    parameter int COUNT_WIDTH  = 16
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   cmd_valid_i,
    output logic                   cmd_ready_o,
    input  logic [1:0]             cmd_op_i,
    input  logic [KEY_WIDTH-1:0]   cmd_key_i,
    input  logic [VALUE_WIDTH-1:0] cmd_value_i,
    input  logic [TAG_WIDTH-1:0]   cmd_tag_i,
    output logic [1:0]             map_op_o,
    output logic [KEY_WIDTH-1:0]   map_key_o,
    output logic [VALUE_WIDTH-1:0] map_value_o,
    output logic                   map_valid_o,
    input  logic                   map_ready_i,
    input  logic [VALUE_WIDTH-1:0] map_rsp_value_i,
    input  logic                   map_rsp_hit_i,
    output logic                   rsp_valid_o,
    input  logic                   rsp_ready_i,
    output logic [TAG_WIDTH-1:0]   rsp_tag_o,
    output logic [1:0]             rsp_op_o,
    output logic [VALUE_WIDTH-1:0] rsp_value_o,
    output logic [1:0]             rsp_status_o,
    output logic [COUNT_WIDTH-1:0] hit_count_o,
    output logic [COUNT_WIDTH-1:0] miss_count_o,
    output logic [COUNT_WIDTH-1:0] full_count_o
);

    localparam int PW = $clog2(CMD_DEPTH);
    localparam int WW = (FULL_TIMEOUT > 1) ? $clog2(FULL_TIMEOUT) : 1;
    localparam logic [WW-1:0] WAIT_LAST = WW'((FULL_TIMEOUT > 0) ? FULL_TIMEOUT - 1 : 0);
    localparam logic [PW:0]   DEPTH_C   = (PW+1)'(CMD_DEPTH);

    localparam logic [1:0] OP_NOP = 2'd0, OP_INSERT = 2'd1, OP_DELETE = 2'd2, OP_LOOKUP = 2'd3;
    localparam logic [1:0] ST_OK = 2'd0, ST_MISS = 2'd1, ST_FULL = 2'd2;

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_RESP} state_e;

    typedef struct packed {
        logic [TAG_WIDTH-1:0]   tag;
        logic [1:0]             op;
        logic [KEY_WIDTH-1:0]   key;
        logic [VALUE_WIDTH-1:0] value;
    } cmd_t;

    state_e state_q, state_d;

    cmd_t             fifo_q [CMD_DEPTH];
    logic [PW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [PW:0]      count_q;
    cmd_t             head, cmd_in, cmd_q;
    logic             push, pop;

    logic [WW-1:0]    wait_q, wait_d;
    logic             issue_done, timeout;

    logic                   rsp_load;
    logic [TAG_WIDTH-1:0]   rsp_tag_d, rsp_tag_q;
    logic [1:0]             rsp_op_d, rsp_op_q;
    logic [VALUE_WIDTH-1:0] rsp_value_d, rsp_value_q;
    logic [1:0]             rsp_status_d, rsp_status_q;
    logic                   hit_inc, miss_inc, full_inc;
    logic [COUNT_WIDTH-1:0] hit_q, miss_q, full_q;

    assign cmd_in = '{tag: cmd_tag_i, op: cmd_op_i, key: cmd_key_i, value: cmd_value_i};
    assign head   = fifo_q[rd_ptr_q];
    assign push   = cmd_valid_i && cmd_ready_o;
    assign pop    = (state_q == S_IDLE) && (count_q != '0);

    // A stalled INSERT gives up on the last permitted wait cycle, so map_valid spans FULL_TIMEOUT cycles.
    assign timeout = (FULL_TIMEOUT != 0) && (wait_q == WAIT_LAST) && !map_ready_i;

    always_comb begin
        issue_done = 1'b1;
        if (cmd_q.op == OP_INSERT) issue_done = map_ready_i || timeout;
    end

    assign wait_d = ((state_q == S_ISSUE) && !issue_done) ? wait_q + 1'b1 : '0;

    // FSM: state register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) state_q <= S_IDLE;
        else         state_q <= state_d;
    end

    // FSM: next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (pop) state_d = (head.op == OP_NOP) ? S_RESP : S_ISSUE;
            S_ISSUE: if (issue_done) state_d = S_RESP;
            S_RESP:  if (rsp_ready_i) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // FSM: outputs
    always_comb begin
        cmd_ready_o = (count_q != DEPTH_C);
        map_valid_o = (state_q == S_ISSUE);
        map_op_o    = map_valid_o ? cmd_q.op    : OP_NOP;
        map_key_o   = map_valid_o ? cmd_q.key   : '0;
        map_value_o = map_valid_o ? cmd_q.value : '0;
        rsp_valid_o = (state_q == S_RESP);
    end

    // Response capture; a NOP is answered straight from the FIFO head.
    always_comb begin
        rsp_load     = 1'b0;
        rsp_tag_d    = cmd_q.tag;
        rsp_op_d     = cmd_q.op;
        rsp_value_d  = '0;
        rsp_status_d = ST_OK;
        hit_inc      = 1'b0;
        miss_inc     = 1'b0;
        full_inc     = 1'b0;
        if (pop && head.op == OP_NOP) begin
            rsp_load  = 1'b1;
            rsp_tag_d = head.tag;
            rsp_op_d  = OP_NOP;
        end else if (state_q == S_ISSUE && issue_done) begin
            rsp_load = 1'b1;
            if (cmd_q.op == OP_LOOKUP) begin
                if (map_rsp_hit_i) begin
                    rsp_value_d = map_rsp_value_i;
                    hit_inc     = 1'b1;
                end else begin
                    rsp_status_d = ST_MISS;
                    miss_inc     = 1'b1;
                end
            end else if (cmd_q.op == OP_INSERT && !map_ready_i) begin
                rsp_status_d = ST_FULL;
                full_inc     = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) fifo_q[wr_ptr_q] <= cmd_in;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            cmd_q        <= '0;
            wait_q       <= '0;
            rsp_tag_q    <= '0;
            rsp_op_q     <= '0;
            rsp_value_q  <= '0;
            rsp_status_q <= '0;
            hit_q        <= '0;
            miss_q       <= '0;
            full_q       <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({push, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
            if (pop) cmd_q <= head;
            wait_q <= wait_d;
            if (rsp_load) begin
                rsp_tag_q    <= rsp_tag_d;
                rsp_op_q     <= rsp_op_d;
                rsp_value_q  <= rsp_value_d;
                rsp_status_q <= rsp_status_d;
            end
            if (hit_inc  && !(&hit_q))  hit_q  <= hit_q  + 1'b1;
            if (miss_inc && !(&miss_q)) miss_q <= miss_q + 1'b1;
            if (full_inc && !(&full_q)) full_q <= full_q + 1'b1;
        end
    end

    assign rsp_tag_o    = rsp_tag_q;
    assign rsp_op_o     = rsp_op_q;
    assign rsp_value_o  = rsp_value_q;
    assign rsp_status_o = rsp_status_q;
    assign hit_count_o  = hit_q;
    assign miss_count_o = miss_q;
    assign full_count_o = full_q;

endmodule

// File: tb/tb_map_client_sequencer.sv
// Directed bench for map_client_sequencer: insert/lookup/delete/nop flow, FULL timeout,
// back-pressure with a full FIFO, and reset during a stalled insert.
module tb_map_client_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cmd_valid, cmd_ready;
    logic [1:0]  cmd_op;
    logic [7:0]  cmd_key;
    logic [15:0] cmd_value;
    logic [3:0]  cmd_tag;
    logic [1:0]  map_op;
    logic [7:0]  map_key;
    logic [15:0] map_value;
    logic        map_valid, map_ready;
    logic [15:0] map_rsp_value;
    logic        map_rsp_hit;
    logic        rsp_valid, rsp_ready;
    logic [3:0]  rsp_tag;
    logic [1:0]  rsp_op;
    logic [15:0] rsp_value;
    logic [1:0]  rsp_status;
    logic [15:0] hit_count, miss_count, full_count;

    int n_checks = 0;
    int n_errors = 0;
    int mv_cnt   = 0;
    int mv0;
    int base;
    logic [31:0] rsp_log[$];

    always #5 clk = ~clk;

    map_client_sequencer dut (
        .clk_i(clk), .rst_ni(rst_n),
        .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready), .cmd_op_i(cmd_op),
        .cmd_key_i(cmd_key), .cmd_value_i(cmd_value), .cmd_tag_i(cmd_tag),
        .map_op_o(map_op), .map_key_o(map_key), .map_value_o(map_value),
        .map_valid_o(map_valid), .map_ready_i(map_ready),
        .map_rsp_value_i(map_rsp_value), .map_rsp_hit_i(map_rsp_hit),
        .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_tag_o(rsp_tag),
        .rsp_op_o(rsp_op), .rsp_value_o(rsp_value), .rsp_status_o(rsp_status),
        .hit_count_o(hit_count), .miss_count_o(miss_count), .full_count_o(full_count)
    );

    // Passive monitors: map_valid cycles and accepted responses {tag, op, status, value}.
    always @(posedge clk) begin
        if (map_valid) mv_cnt <= mv_cnt + 1;
        if (rsp_valid && rsp_ready) rsp_log.push_back({8'h0, rsp_tag, rsp_op, rsp_status, rsp_value});
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [1:0] op, input logic [7:0] key, input logic [15:0] val,
                        input logic [3:0] tag);
        cmd_valid = 1'b1; cmd_op = op; cmd_key = key; cmd_value = val; cmd_tag = tag;
        check("push_ready", cmd_ready, 1'b1);
        tick();
        cmd_valid = 1'b0;
    endtask

    function automatic logic [31:0] rsp_word(input logic [3:0] tag, input logic [1:0] op,
                                              input logic [1:0] st, input logic [15:0] val);
        return {8'h0, tag, op, st, val};
    endfunction

    initial begin
        rst_n = 1'b0; cmd_valid = 1'b0; cmd_op = 2'd0; cmd_key = '0; cmd_value = '0; cmd_tag = '0;
        map_ready = 1'b1; map_rsp_value = '0; map_rsp_hit = 1'b0; rsp_ready = 1'b1;
        #12;
        check("rst_cmd_ready", cmd_ready, 1'b1);
        check("rst_map_valid", map_valid, 1'b0);
        check("rst_map_fields", {map_op, map_key, map_value}, '0);
        check("rst_rsp_valid", rsp_valid, 1'b0);
        check("rst_rsp_fields", {rsp_tag, rsp_op, rsp_value, rsp_status}, '0);
        check("rst_counters", {hit_count, miss_count}, '0);
        check("rst_full_count", full_count, '0);
        rst_n = 1'b1;
        tick();

        // INSERT with map ready: one issue cycle, response at T+3
        mv0 = mv_cnt;
        push(2'd1, 8'h12, 16'hBEEF, 4'd1);
        check("ins_idle_mv", map_valid, 1'b0);
        tick();
        check("ins_mv", map_valid, 1'b1);
        check("ins_map_fields", {map_op, map_key, map_value}, {2'd1, 8'h12, 16'hBEEF});
        tick();
        check("ins_rsp_valid", rsp_valid, 1'b1);
        check("ins_rsp", rsp_word(rsp_tag, rsp_op, rsp_status, rsp_value), rsp_word(4'd1, 2'd1, 2'd0, 16'h0));
        check("ins_map_after", map_valid, 1'b0);
        tick();
        check("ins_mv_cycles", mv_cnt - mv0, 1);
        check("ins_rsp_drop", rsp_valid, 1'b0);

        // LOOKUP hit then miss
        map_rsp_hit = 1'b1; map_rsp_value = 16'hBEEF;
        push(2'd3, 8'h12, 16'h0, 4'd2);
        tick(); tick();
        check("lkh_rsp", rsp_word(rsp_tag, rsp_op, rsp_status, rsp_value), rsp_word(4'd2, 2'd3, 2'd0, 16'hBEEF));
        check("lkh_hit_count", hit_count, 16'd1);
        tick();
        map_rsp_hit = 1'b0; map_rsp_value = 16'h1234;
        push(2'd3, 8'h12, 16'h0, 4'd3);
        tick(); tick();
        check("lkm_rsp", rsp_word(rsp_tag, rsp_op, rsp_status, rsp_value), rsp_word(4'd3, 2'd3, 2'd1, 16'h0));
        check("lkm_counts", {hit_count, miss_count}, {16'd1, 16'd1});
        tick();

        // INSERT into a full map: FULL after 8 issue cycles
        map_ready = 1'b0; mv0 = mv_cnt;
        push(2'd1, 8'h34, 16'h5555, 4'd4);
        tick();
        for (int i = 0; i < 8; i++) begin
            if (map_valid !== 1'b1 || rsp_valid !== 1'b0) begin
                check("full_wait_state", {map_valid, rsp_valid}, 2'b10);
            end
            tick();
        end
        check("full_mv_cycles", mv_cnt - mv0, 8);
        check("full_rsp_valid", rsp_valid, 1'b1);
        check("full_rsp", rsp_word(rsp_tag, rsp_op, rsp_status, rsp_value), rsp_word(4'd4, 2'd1, 2'd2, 16'h0));
        check("full_count", full_count, 16'd1);
        tick();

        // map_ready rises on the third issue cycle
        mv0 = mv_cnt;
        push(2'd1, 8'h35, 16'h6666, 4'd5);
        tick(); tick(); tick();
        map_ready = 1'b1;
        tick();
        check("late_rsp", rsp_word(rsp_tag, rsp_op, rsp_status, rsp_value), rsp_word(4'd5, 2'd1, 2'd0, 16'h0));
        check("late_mv_cycles", mv_cnt - mv0, 3);
        check("late_full_count", full_count, 16'd1);
        tick();

        // Five back-to-back commands with the response port stalled
        rsp_ready = 1'b0; map_rsp_hit = 1'b1; map_rsp_value = 16'h0A0A;
        base = rsp_log.size();
        push(2'd1, 8'h01, 16'h1111, 4'd8);
        push(2'd2, 8'h02, 16'h0, 4'd9);
        push(2'd3, 8'h03, 16'h0, 4'd10);
        push(2'd0, 8'h04, 16'h0, 4'd11);
        push(2'd3, 8'h05, 16'h0, 4'd12);
        check("bp_cmd_ready", cmd_ready, 1'b0);
        cmd_valid = 1'b1; cmd_op = 2'd0; cmd_tag = 4'd15;
        for (int i = 0; i < 4; i++) begin
            if (rsp_valid !== 1'b1 || rsp_tag !== 4'd8 || rsp_op !== 2'd1 || rsp_status !== 2'd0) begin
                check("bp_hold", {rsp_valid, rsp_tag, rsp_op, rsp_status}, {1'b1, 4'd8, 2'd1, 2'd0});
            end
            tick();
        end
        check("bp_held_tag", rsp_tag, 4'd8);
        check("bp_full_refuse", cmd_ready, 1'b0);
        cmd_valid = 1'b0;
        rsp_ready = 1'b1;
        for (int i = 0; i < 40 && rsp_log.size() < base + 5; i++) tick();
        check("bp_rsp_count", rsp_log.size() - base, 5);
        if (rsp_log.size() >= base + 5) begin
            check("bp_rsp0", rsp_log[base+0], rsp_word(4'd8,  2'd1, 2'd0, 16'h0));
            check("bp_rsp1", rsp_log[base+1], rsp_word(4'd9,  2'd2, 2'd0, 16'h0));
            check("bp_rsp2", rsp_log[base+2], rsp_word(4'd10, 2'd3, 2'd0, 16'h0A0A));
            check("bp_rsp3", rsp_log[base+3], rsp_word(4'd11, 2'd0, 2'd0, 16'h0));
            check("bp_rsp4", rsp_log[base+4], rsp_word(4'd12, 2'd3, 2'd0, 16'h0A0A));
        end
        check("bp_hit_count", hit_count, 16'd3);
        tick();

        // NOP: never drives the map, response at T+2
        mv0 = mv_cnt;
        push(2'd0, 8'hFF, 16'hFFFF, 4'd7);
        check("nop_t1_rsp", rsp_valid, 1'b0);
        tick();
        check("nop_rsp_valid", rsp_valid, 1'b1);
        check("nop_rsp", rsp_word(rsp_tag, rsp_op, rsp_status, rsp_value), rsp_word(4'd7, 2'd0, 2'd0, 16'h0));
        tick();
        check("nop_mv_cycles", mv_cnt - mv0, 0);

        // Reset during a stalled INSERT with another command queued
        map_ready = 1'b0;
        push(2'd1, 8'h40, 16'h4444, 4'd9);
        push(2'd2, 8'h41, 16'h0, 4'd6);
        check("rstmid_issue", map_valid, 1'b1);
        rst_n = 1'b0;
        #1;
        check("rstmid_mv", map_valid, 1'b0);
        check("rstmid_cmd_ready", cmd_ready, 1'b1);
        check("rstmid_rsp_valid", rsp_valid, 1'b0);
        tick();
        rst_n = 1'b1; map_ready = 1'b1;
        base = rsp_log.size(); mv0 = mv_cnt;
        for (int i = 0; i < 6; i++) tick();
        check("rstmid_no_rsp", rsp_log.size() - base, 0);
        check("rstmid_no_issue", mv_cnt - mv0, 0);
        check("rstmid_counters", {hit_count, full_count}, '0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
